// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush, forwarding and perf counters for a 5-stage pipeline
module hazard_ctrl #(
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_ID_rs,
    input  logic [4:0]       i_ID_rt,
    input  logic             i_ID_uses_rt,
    input  logic             i_EX_mem_read,
    input  logic [4:0]       i_EX_write_reg,
    input  logic [4:0]       i_EX_rs,
    input  logic [4:0]       i_EX_rt,
    input  logic             i_MEM_reg_write,
    input  logic [4:0]       i_MEM_write_reg,
    input  logic             i_WB_reg_write,
    input  logic [4:0]       i_WB_write_reg,
    input  logic             i_branch_taken,
    output logic             o_pc_write,
    output logic             o_IF_ID_write,
    output logic             o_IF_ID_flush,
    output logic             o_ID_EX_flush,
    output logic             o_EX_MEM_flush,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_state,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_events
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_USE_STALLS - 1);

    state_t     state, next_state;
    logic [1:0] remain, next_remain;
    logic       hazard;
    logic       stall_now;

    assign hazard = i_EX_mem_read && (i_EX_write_reg != 5'd0) &&
                    ((i_EX_write_reg == i_ID_rs) ||
                     (i_ID_uses_rt && (i_EX_write_reg == i_ID_rt)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= RUN;
            remain <= 2'd0;
        end else begin
            state  <= next_state;
            remain <= next_remain;
        end
    end

    always_comb begin
        next_state     = state;
        next_remain    = remain;
        stall_now      = 1'b0;
        o_pc_write     = 1'b1;
        o_IF_ID_write  = 1'b1;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_flush  = 1'b0;
        o_EX_MEM_flush = 1'b0;
        if (i_branch_taken) begin
            o_IF_ID_flush  = 1'b1;
            o_ID_EX_flush  = 1'b1;
            o_EX_MEM_flush = 1'b1;
            next_state     = RUN;
            next_remain    = 2'd0;
        end else if (state == STALL) begin
            stall_now   = 1'b1;
            next_remain = remain - 2'd1;
            if (remain == 2'd1) next_state = RUN;
        end else if (hazard) begin
            stall_now = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
                next_state  = STALL;
                next_remain = STALL_RELOAD;
            end
        end
        if (stall_now) begin
            o_pc_write    = 1'b0;
            o_IF_ID_write = 1'b0;
            o_ID_EX_flush = 1'b1;
        end
        // Keep the pipeline frozen and unflushed while reset is held.
        if (!i_rst_n) begin
            o_pc_write     = 1'b0;
            o_IF_ID_write  = 1'b0;
            o_IF_ID_flush  = 1'b0;
            o_ID_EX_flush  = 1'b0;
            o_EX_MEM_flush = 1'b0;
        end
    end

    always_comb begin
        o_fwd_a = 2'b00;
        o_fwd_b = 2'b00;
        if (i_rst_n) begin
            if (i_MEM_reg_write && i_MEM_write_reg != 5'd0 && i_MEM_write_reg == i_EX_rs)
                o_fwd_a = 2'b10;
            else if (i_WB_reg_write && i_WB_write_reg != 5'd0 && i_WB_write_reg == i_EX_rs)
                o_fwd_a = 2'b01;
            if (i_MEM_reg_write && i_MEM_write_reg != 5'd0 && i_MEM_write_reg == i_EX_rt)
                o_fwd_b = 2'b10;
            else if (i_WB_reg_write && i_WB_write_reg != 5'd0 && i_WB_write_reg == i_EX_rt)
                o_fwd_b = 2'b01;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cycles <= '0;
            o_flush_events <= '0;
        end else begin
            if (stall_now && o_stall_cycles != {CNT_W{1'b1}})
                o_stall_cycles <= o_stall_cycles + 1'b1;
            if (i_branch_taken && o_flush_events != {CNT_W{1'b1}})
                o_flush_events <= o_flush_events + 1'b1;
        end
    end

    assign o_state = state;

endmodule
